// File: rtl/shift_register_pkg.sv
// Shared definitions for the parallel register path: FSM encodings and the
// default word width used by the register, serializer and serial receiver.
package shift_register_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int SR_WIDTH = 4;

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter tracking the bits remaining in the current word.
// The zero flag marks the last bit of a word.
module shift_bit_counter
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] load_val,
  input  logic          load_en,
  input  logic          dec_en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/shift_register_serializer.sv
// Parallel-in serial-out transmitter with a load/ready handshake; accepts a
// new word on the last-bit cycle so consecutive words stream without a gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word in flight, sout held low, ready to load
// ST_SHIFT | word bits on sout, one per cycle; ready again on last bit
module shift_register_serializer
  import shift_register_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_bar,
  output logic             sout_valid,
  output logic             done,
  output logic [WIDTH-1:0] Q
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             cnt_zero;
  logic             load_acc;
  logic             cnt_dec;

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_val (CW'(WIDTH - 1)),
    .load_en  (load_acc),
    .dec_en   (cnt_dec),
    .zero     (cnt_zero)
  );

  // The counter is zero in IDLE, so ready only depends on registered state.
  assign ready    = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && cnt_zero);
  assign load_acc = load && ready;
  assign cnt_dec  = (state_q == ST_SHIFT) && !cnt_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    if (load_acc) begin
      state_d = ST_SHIFT;
      sr_d    = D;
    end else if (state_q == ST_SHIFT) begin
      if (!cnt_zero) begin
        sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
      end else begin
        state_d = ST_IDLE;
        sr_d    = '0;
      end
    end
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    if (state_q == ST_SHIFT) begin
      sout       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
      sout_valid = 1'b1;
      done       = cnt_zero;
    end
  end

  assign sout_bar = ~sout;
  assign Q        = sr_q;

endmodule

// File: tb/tb_shift_register_serializer.sv
// Directed bench for the serializer: reset, single word, back-to-back,
// ignored load while busy, reset mid-word and LSB-first ordering.
module tb_shift_register_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] d_m, d_l;
  logic       load_m, load_l;
  logic       ready_m, sout_m, sout_bar_m, valid_m, done_m;
  logic [3:0] q_m;
  logic       ready_l, sout_l, sout_bar_l, valid_l, done_l;
  logic [3:0] q_l;

  int n_cmp = 0;
  int n_bad = 0;

  shift_register_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .D(d_m), .load(load_m), .ready(ready_m),
    .sout(sout_m), .sout_bar(sout_bar_m), .sout_valid(valid_m),
    .done(done_m), .Q(q_m)
  );

  shift_register_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .D(d_l), .load(load_l), .ready(ready_l),
    .sout(sout_l), .sout_bar(sout_bar_l), .sout_valid(valid_l),
    .done(done_l), .Q(q_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_m = 1'b1; d_m = 4'b1111; load_l = 1'b1; d_l = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({sout_m, sout_bar_m, valid_m, done_m, ready_m, q_m} !== {5'b01001, 4'b0000}) begin
        n_bad++;
        $display("FAIL reset[%0d]: got sout/bar/valid/done/ready/Q=%b%b%b%b%b/%b want 01001/0000",
                 i, sout_m, sout_bar_m, valid_m, done_m, ready_m, q_m);
      end
      n_cmp++;
      if ({valid_l, ready_l, q_l} !== 6'b010000) begin
        n_bad++;
        $display("FAIL reset_lsb[%0d]: got valid/ready/Q=%b%b/%b want 01/0000", i, valid_l, ready_l, q_l);
      end
    end
    rst = 1'b0; load_m = 1'b0; load_l = 1'b0; d_m = '0; d_l = '0;
    tick();
    n_cmp++;
    if ({valid_m, ready_m, q_m} !== 6'b010000) begin
      n_bad++;
      $display("FAIL reset_release: got valid/ready/Q=%b%b/%b want 01/0000", valid_m, ready_m, q_m);
    end
  endtask

  task automatic test_single_word();
    logic [3:0] exp_sout  = 4'b1010;
    logic [3:0] exp_done  = 4'b0001;
    logic [3:0] exp_ready = 4'b0001;
    logic [3:0] exp_q [4] = '{4'b1010, 4'b0100, 4'b1000, 4'b0000};
    d_m = 4'b1010; load_m = 1'b1;
    tick();
    load_m = 1'b0; d_m = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({sout_m, sout_bar_m, valid_m, done_m, ready_m} !==
          {exp_sout[3-i], ~exp_sout[3-i], 1'b1, exp_done[3-i], exp_ready[3-i]}) begin
        n_bad++;
        $display("FAIL single[%0d]: got sout/bar/valid/done/ready=%b%b%b%b%b want %b%b1%b%b",
                 i, sout_m, sout_bar_m, valid_m, done_m, ready_m,
                 exp_sout[3-i], ~exp_sout[3-i], exp_done[3-i], exp_ready[3-i]);
      end
      n_cmp++;
      if (q_m !== exp_q[i]) begin
        n_bad++;
        $display("FAIL single_q[%0d]: got %b want %b", i, q_m, exp_q[i]);
      end
      tick();
    end
    n_cmp++;
    if ({sout_m, sout_bar_m, valid_m, done_m, ready_m, q_m} !== {5'b01001, 4'b0000}) begin
      n_bad++;
      $display("FAIL single_idle: got sout/bar/valid/done/ready/Q=%b%b%b%b%b/%b want 01001/0000",
               sout_m, sout_bar_m, valid_m, done_m, ready_m, q_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_sout = 8'b1110_1011;
    logic [7:0] exp_done = 8'b0001_0001;
    d_m = 4'b1110; load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({valid_m, sout_m, done_m} !== {1'b1, exp_sout[7-i], exp_done[7-i]}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got valid/sout/done=%b%b%b want 1%b%b",
                 i, valid_m, sout_m, done_m, exp_sout[7-i], exp_done[7-i]);
      end
      if (i == 3) begin
        d_m = 4'b1011; load_m = 1'b1;
      end else begin
        load_m = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if ({valid_m, ready_m, q_m} !== 6'b010000) begin
      n_bad++;
      $display("FAIL b2b_idle: got valid/ready/Q=%b%b/%b want 01/0000", valid_m, ready_m, q_m);
    end
  endtask

  task automatic test_load_while_busy();
    logic [3:0] exp_sout = 4'b1011;
    d_m = 4'b1011; load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({valid_m, sout_m} !== {1'b1, exp_sout[3-i]} || q_m === 4'b1111) begin
        n_bad++;
        $display("FAIL busy[%0d]: got valid/sout=%b%b Q=%b want 1%b Q!=1111",
                 i, valid_m, sout_m, q_m, exp_sout[3-i]);
      end
      if (i == 1) begin
        d_m = 4'b1111; load_m = 1'b1;
      end else begin
        load_m = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if ({valid_m, ready_m, q_m} !== 6'b010000) begin
      n_bad++;
      $display("FAIL busy_idle: got valid/ready/Q=%b%b/%b want 01/0000", valid_m, ready_m, q_m);
    end
  endtask

  task automatic test_reset_mid_word();
    d_m = 4'b1001; load_m = 1'b1;
    tick();
    load_m = 1'b0;
    n_cmp++;
    if ({valid_m, sout_m, q_m} !== 6'b111001) begin
      n_bad++;
      $display("FAIL midrst_bit1: got valid/sout/Q=%b%b/%b want 11/1001", valid_m, sout_m, q_m);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({sout_m, valid_m, ready_m, done_m, q_m} !== 8'b0010_0000) begin
      n_bad++;
      $display("FAIL midrst: got sout/valid/ready/done/Q=%b%b%b%b/%b want 0010/0000",
               sout_m, valid_m, ready_m, done_m, q_m);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({done_m, valid_m} !== 2'b00) begin
        n_bad++;
        $display("FAIL midrst_after[%0d]: got done/valid=%b%b want 00", i, done_m, valid_m);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_sout = 4'b1101;
    logic [3:0] exp_done = 4'b0001;
    logic [3:0] exp_q [4] = '{4'b1011, 4'b0101, 4'b0010, 4'b0001};
    d_l = 4'b1011; load_l = 1'b1;
    tick();
    load_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({valid_l, sout_l, sout_bar_l, done_l, q_l} !==
          {1'b1, exp_sout[3-i], ~exp_sout[3-i], exp_done[3-i], exp_q[i]}) begin
        n_bad++;
        $display("FAIL lsb[%0d]: got valid/sout/bar/done/Q=%b%b%b%b/%b want 1%b%b%b/%b",
                 i, valid_l, sout_l, sout_bar_l, done_l, q_l,
                 exp_sout[3-i], ~exp_sout[3-i], exp_done[3-i], exp_q[i]);
      end
      tick();
    end
    n_cmp++;
    if ({valid_l, ready_l, q_l} !== 6'b010000) begin
      n_bad++;
      $display("FAIL lsb_idle: got valid/ready/Q=%b%b/%b want 01/0000", valid_l, ready_l, q_l);
    end
  endtask

  initial begin
    rst = 1'b1; load_m = 1'b0; load_l = 1'b0; d_m = '0; d_l = '0;
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid_word();
    test_lsb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
